uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_pkg.sv | 16 +
 rtl/uart_frame_ctrl_if.sv | 21 ++
 rtl/uart_frame_buf.sv | 16 +
 rtl/uart_frame_ctrl.sv | 114 +++++++++++
 tb/tb_uart_frame_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding, error codes and default sync marker
package uart_frame_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_COMMIT
  } state_e;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: receive strobe, write handshake and frame status bundle
interface uart_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  modport master (
    output rx_data, rx_valid, wr_ready,
    input  wr_addr, wr_data, wr_valid, frame_ok, frame_err, err_code, busy
  );
  modport slave (
    input  rx_data, rx_valid, wr_ready,
    output wr_addr, wr_data, wr_valid, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload register file, one write port, combinational read
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses SYNC/ADDR/LEN/payload/CHK frames and replays them as writes
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  uart_frame_ctrl_if.slave bus
);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  state_e        state_q;
  logic [7:0]    addr_q, len_q, idx_q, sum_q, sum_d, rd_data;
  logic [TW-1:0] tmo_q;
  logic          wr_valid_q, frame_ok_q, frame_err_q;
  logic [1:0]    err_code_q;
  logic          in_frame, idle_cyc, tmo_hit, last_idx;
  assign sum_d    = sum_q + bus.rx_data;
  assign last_idx = idx_q == len_q - 8'd1;
  assign in_frame = state_q inside {S_ADDR, S_LEN, S_PAYLOAD, S_CHK};
  assign idle_cyc = in_frame && !bus.rx_valid;
  assign tmo_hit  = idle_cyc && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(IW)) u_buf (
    .clk     (clk),
    .we_i    (state_q == S_PAYLOAD && bus.rx_valid),
    .waddr_i (idx_q[IW-1:0]),
    .wdata_i (bus.rx_data),
    .raddr_i (idx_q[IW-1:0]),
    .rdata_o (rd_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      wr_valid_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tmo_q       <= idle_cyc ? tmo_q + TW'(1) : '0;
      if (tmo_hit) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TMO;
      end else begin
        case (state_q)
          S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state_q <= S_ADDR;
            sum_q   <= '0;
          end
          S_ADDR: if (bus.rx_valid) begin
            addr_q  <= bus.rx_data;
            sum_q   <= sum_d;
            state_q <= S_LEN;
          end
          S_LEN: if (bus.rx_valid) begin
            len_q <= bus.rx_data;
            sum_q <= sum_d;
            idx_q <= '0;
            if (bus.rx_data > MAX_B) begin
              state_q     <= S_IDLE;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end else state_q <= bus.rx_data == 8'd0 ? S_CHK : S_PAYLOAD;
          end
          S_PAYLOAD: if (bus.rx_valid) begin
            sum_q   <= sum_d;
            idx_q   <= last_idx ? '0 : idx_q + 8'd1;
            state_q <= last_idx ? S_CHK : S_PAYLOAD;
          end
          S_CHK: if (bus.rx_valid) begin
            sum_q <= sum_d;
            idx_q <= '0;
            if (sum_d != 8'd0) begin
              state_q     <= S_IDLE;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
            end else if (len_q == 8'd0) begin
              state_q    <= S_IDLE;
              frame_ok_q <= 1'b1;
            end else begin
              state_q    <= S_COMMIT;
              wr_valid_q <= 1'b1;
            end
          end
          S_COMMIT: if (bus.wr_ready) begin
            idx_q      <= last_idx ? '0 : idx_q + 8'd1;
            state_q    <= last_idx ? S_IDLE : S_COMMIT;
            wr_valid_q <= !last_idx;
            frame_ok_q <= last_idx;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign bus.wr_addr   = addr_q + idx_q;
  assign bus.wr_data   = rd_data;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frame scenarios with hand-computed expectations
module tb_uart_frame_ctrl;
  localparam int TMO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cnt = 0;
  int   hs0;
  uart_frame_ctrl_if bus ();
  uart_frame_ctrl #(.MAX_LEN(16), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && bus.wr_valid && bus.wr_ready) hs_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask
  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(bus.wr_valid), 32'd1);
    chk({tag, ".addr"}, 32'(bus.wr_addr), 32'(a));
    chk({tag, ".data"}, 32'(bus.wr_data), 32'(d));
  endtask
  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.wr_ready = 1'b1;
    repeat (2) tick();
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rst.frame_ok", 32'(bus.frame_ok), 32'd0);
    chk("rst.frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst.err_code", 32'(bus.err_code), 32'd0);
    rst = 1'b0;
    tick();
    send(8'h33);
    chk("idle_ignore.busy", 32'(bus.busy), 32'd0);
    chk("idle_ignore.err", 32'(bus.frame_err), 32'd0);
    // good frame, three writes back to back
    hs0 = hs_cnt;
    send(8'hA5);
    chk("good.busy", 32'(bus.busy), 32'd1);
    send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("good.pre_valid", 32'(bus.wr_valid), 32'd0);
    send(8'h87);
    chk_wr("good.w0", 8'h10, 8'h11);
    tick();
    chk_wr("good.w1", 8'h11, 8'h22);
    tick();
    chk_wr("good.w2", 8'h12, 8'h33);
    chk("good.ok_early", 32'(bus.frame_ok), 32'd0);
    tick();
    chk("good.done_valid", 32'(bus.wr_valid), 32'd0);
    chk("good.frame_ok", 32'(bus.frame_ok), 32'd1);
    chk("good.no_err", 32'(bus.frame_err), 32'd0);
    chk("good.writes", 32'(hs_cnt - hs0), 32'd3);
    tick();
    chk("good.ok_pulse", 32'(bus.frame_ok), 32'd0);
    chk("good.idle", 32'(bus.busy), 32'd0);
    // checksum error
    hs0 = hs_cnt;
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h88);
    chk("chk.frame_err", 32'(bus.frame_err), 32'd1);
    chk("chk.err_code", 32'(bus.err_code), 32'd2);
    chk("chk.no_ok", 32'(bus.frame_ok), 32'd0);
    tick();
    chk("chk.err_pulse", 32'(bus.frame_err), 32'd0);
    chk("chk.code_held", 32'(bus.err_code), 32'd2);
    chk("chk.busy", 32'(bus.busy), 32'd0);
    chk("chk.wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("chk.writes", 32'(hs_cnt - hs0), 32'd0);
    // length error then a good one-byte frame
    send(8'hA5); send(8'h00); send(8'h11);
    chk("len.frame_err", 32'(bus.frame_err), 32'd1);
    chk("len.err_code", 32'(bus.err_code), 32'd1);
    chk("len.busy", 32'(bus.busy), 32'd0);
    hs0 = hs_cnt;
    send(8'hA5); send(8'h20); send(8'h01); send(8'h55); send(8'h8A);
    chk_wr("len.next_w0", 8'h20, 8'h55);
    tick();
    chk("len.next_ok", 32'(bus.frame_ok), 32'd1);
    chk("len.next_no_err", 32'(bus.frame_err), 32'd0);
    chk("len.code_held", 32'(bus.err_code), 32'd1);
    chk("len.next_writes", 32'(hs_cnt - hs0), 32'd1);
    // zero-length frame commits with no writes
    hs0 = hs_cnt;
    send(8'hA5); send(8'h40); send(8'h00); send(8'hC0);
    chk("zero.frame_ok", 32'(bus.frame_ok), 32'd1);
    chk("zero.busy", 32'(bus.busy), 32'd0);
    chk("zero.writes", 32'(hs_cnt - hs0), 32'd0);
    // address wrap with alternating backpressure; a stray byte while stalled
    bus.wr_ready = 1'b0;
    send(8'hA5); send(8'hFE); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hCE);
    chk_wr("wrap.w0", 8'hFE, 8'hAA);
    send(8'h99);
    chk_wr("wrap.w0_stall", 8'hFE, 8'hAA);
    chk("wrap.rx_ignored", 32'(bus.frame_err), 32'd0);
    bus.wr_ready = 1'b1;
    tick();
    chk_wr("wrap.w1", 8'hFF, 8'hBB);
    bus.wr_ready = 1'b0;
    tick();
    chk_wr("wrap.w1_stall", 8'hFF, 8'hBB);
    bus.wr_ready = 1'b1;
    tick();
    chk_wr("wrap.w2", 8'h00, 8'hCC);
    bus.wr_ready = 1'b0;
    tick();
    chk_wr("wrap.w2_stall", 8'h00, 8'hCC);
    chk("wrap.ok_early", 32'(bus.frame_ok), 32'd0);
    bus.wr_ready = 1'b1;
    tick();
    chk("wrap.done_valid", 32'(bus.wr_valid), 32'd0);
    chk("wrap.frame_ok", 32'(bus.frame_ok), 32'd1);
    // timeout after TMO silent cycles
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
    repeat (TMO - 1) tick();
    chk("tmo.not_early", 32'(bus.frame_err), 32'd0);
    chk("tmo.busy_wait", 32'(bus.busy), 32'd1);
    tick();
    chk("tmo.frame_err", 32'(bus.frame_err), 32'd1);
    chk("tmo.err_code", 32'(bus.err_code), 32'd3);
    tick();
    chk("tmo.idle", 32'(bus.busy), 32'd0);
    chk("tmo.pulse", 32'(bus.frame_err), 32'd0);
    // reset while stalled in commit
    bus.wr_ready = 1'b0;
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h87);
    chk_wr("rstc.w0", 8'h10, 8'h11);
    hs0 = hs_cnt;
    rst = 1'b1;
    tick();
    chk("rstc.wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rstc.frame_ok", 32'(bus.frame_ok), 32'd0);
    chk("rstc.frame_err", 32'(bus.frame_err), 32'd0);
    chk("rstc.busy", 32'(bus.busy), 32'd0);
    chk("rstc.err_code", 32'(bus.err_code), 32'd0);
    rst = 1'b0;
    bus.wr_ready = 1'b1;
    repeat (3) tick();
    chk("rstc.quiet_valid", 32'(bus.wr_valid), 32'd0);
    chk("rstc.quiet_ok", 32'(bus.frame_ok), 32'd0);
    chk("rstc.writes", 32'(hs_cnt - hs0), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
